// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: op codes, writeback selects, FSM
// encoding, and the stage payload structures that move through it.
package memory_stage_pkg;

    localparam logic [4:0] MEN_X   = 5'd0;
    localparam logic [4:0] MEN_SB  = 5'd1;
    localparam logic [4:0] MEN_SH  = 5'd2;
    localparam logic [4:0] MEN_SW  = 5'd3;
    localparam logic [4:0] MEN_LB  = 5'd4;
    localparam logic [4:0] MEN_LBU = 5'd5;
    localparam logic [4:0] MEN_LH  = 5'd6;
    localparam logic [4:0] MEN_LHU = 5'd7;
    localparam logic [4:0] MEN_LW  = 5'd8;

    localparam logic [3:0] WB_X   = 4'd0;
    localparam logic [3:0] WB_ALU = 4'd1;
    localparam logic [3:0] WB_MEM = 4'd2;
    localparam logic [3:0] WB_PC  = 4'd3;
    localparam logic [3:0] WB_CSR = 4'd4;

    localparam logic [2:0]  CSR_X     = 3'd0;
    localparam logic        REN_X     = 1'b0;
    localparam logic [31:0] REGPC_NOP = 32'hffffffff;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_WAIT_DATA,
        ST_DRAIN
    } mem_state_e;

    typedef struct packed {
        logic [31:0] reg_pc;
        logic [31:0] alu_out;
        logic [4:0]  mem_wen;
        logic [31:0] rs2_data;
        logic        rf_wen;
        logic [3:0]  wb_sel;
        logic [4:0]  wb_addr;
        logic [2:0]  csr_cmd;
        logic [31:0] op1_data;
        logic [31:0] imm_i;
        logic        jmp_flg;
        logic        inst_is_ecall;
    } stage_t;

    typedef struct packed {
        logic [31:0] reg_pc;
        logic [31:0] alu_out;
        logic [31:0] op1_data;
        logic [31:0] imm_i;
        logic        rf_wen;
        logic        jmp_flg;
        logic        inst_is_ecall;
        logic [3:0]  wb_sel;
        logic [4:0]  wb_addr;
        logic [2:0]  csr_cmd;
        logic [31:0] mem_rdata;
        logic        misaligned;
    } wb_t;

    function automatic logic is_store(input logic [4:0] men);
        return men inside {MEN_SB, MEN_SH, MEN_SW};
    endfunction

    function automatic logic is_load(input logic [4:0] men);
        return men inside {MEN_LB, MEN_LBU, MEN_LH, MEN_LHU, MEN_LW};
    endfunction

    function automatic logic is_misaligned(input logic [4:0] men, input logic [1:0] offset);
        case (men)
            MEN_SH, MEN_LH, MEN_LHU: return offset[0];
            MEN_SW, MEN_LW:          return |offset;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Picks the addressed byte/half out of a loaded word and extends it to 32 bits.
module memory_stage_load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [4:0]  men,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        result   = '0;
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (men)
            MEN_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEN_LBU: result = {24'd0, byte_sel};
            MEN_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEN_LHU: result = {16'd0, half_sel};
            MEN_LW:  result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on a request/response port,
// stalls upstream while an access is outstanding, and registers results for writeback.
module memory_stage #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] REGPC_NOP = 32'hffffffff
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_branch_hazard,
    input  logic [31:0]       input_reg_pc,
    input  logic [31:0]       input_alu_out,
    input  logic [4:0]        input_mem_wen,
    input  logic [31:0]       input_rs2_data,
    input  logic              input_rf_wen,
    input  logic [3:0]        input_wb_sel,
    input  logic [4:0]        input_wb_addr,
    input  logic [2:0]        input_csr_cmd,
    input  logic [31:0]       input_op1_data,
    input  logic [31:0]       input_imm_i,
    input  logic              input_jmp_flg,
    input  logic              input_inst_is_ecall,
    output logic              mem_stall_flg,
    output logic              dmem_cmd_start,
    output logic              dmem_cmd_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wmask,
    input  logic              dmem_cmd_ready,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_rdata_valid,
    output logic [31:0]       output_reg_pc,
    output logic [31:0]       output_alu_out,
    output logic [31:0]       output_op1_data,
    output logic [31:0]       output_imm_i,
    output logic              output_rf_wen,
    output logic              output_jmp_flg,
    output logic              output_inst_is_ecall,
    output logic [3:0]        output_wb_sel,
    output logic [4:0]        output_wb_addr,
    output logic [2:0]        output_csr_cmd,
    output logic [31:0]       output_mem_rdata,
    output logic              output_misaligned
);

    import memory_stage_pkg::*;

    mem_state_e  state, state_next;
    stage_t      in_stage, saved, cur;
    wb_t         wb_q, wb_next;
    logic        flush, is_mem, store, misaligned, mem_req;
    logic        stall, cmd_start, emit;
    logic [31:0] load_result;

    function automatic stage_t stage_nop();
        stage_t s;
        s         = '0;
        s.reg_pc  = REGPC_NOP;
        s.mem_wen = MEN_X;
        return s;
    endfunction

    function automatic wb_t wb_bubble();
        wb_t w;
        w        = '0;
        w.reg_pc = REGPC_NOP;
        return w;
    endfunction

    assign in_stage = '{reg_pc: input_reg_pc, alu_out: input_alu_out, mem_wen: input_mem_wen,
                        rs2_data: input_rs2_data, rf_wen: input_rf_wen, wb_sel: input_wb_sel,
                        wb_addr: input_wb_addr, csr_cmd: input_csr_cmd, op1_data: input_op1_data,
                        imm_i: input_imm_i, jmp_flg: input_jmp_flg,
                        inst_is_ecall: input_inst_is_ecall};

    // IDLE always works on the live inputs; the copy captured there carries the
    // instruction through the wait states even if the ports change underneath.
    assign cur   = (state == ST_IDLE) ? in_stage : saved;
    assign flush = wb_branch_hazard;

    always_comb begin
        store      = is_store(cur.mem_wen);
        is_mem     = store | is_load(cur.mem_wen);
        misaligned = is_misaligned(cur.mem_wen, cur.alu_out[1:0]);
        mem_req    = is_mem & ~misaligned;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        cmd_start  = 1'b0;
        emit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req && !flush) begin
                    cmd_start = 1'b1;
                    if (!dmem_cmd_ready) begin
                        stall      = 1'b1;
                        state_next = ST_WAIT_READY;
                    end else if (store) begin
                        emit = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_next = ST_WAIT_DATA;
                    end
                end else begin
                    emit = ~flush;
                end
            end
            ST_WAIT_READY: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    cmd_start = 1'b1;
                    if (!dmem_cmd_ready) begin
                        stall = 1'b1;
                    end else if (store) begin
                        emit       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stall      = 1'b1;
                        state_next = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (dmem_rdata_valid) begin
                    emit       = ~flush;
                    state_next = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (flush) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dmem_rdata_valid) state_next = ST_IDLE;
                else                  stall      = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    memory_stage_load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (cur.alu_out[1:0]),
        .men    (cur.mem_wen),
        .result (load_result)
    );

    always_comb begin
        wb_next = wb_bubble();
        if (emit) begin
            wb_next.reg_pc        = cur.reg_pc;
            wb_next.alu_out       = cur.alu_out;
            wb_next.op1_data      = cur.op1_data;
            wb_next.imm_i         = cur.imm_i;
            wb_next.rf_wen        = cur.rf_wen & ~misaligned;
            wb_next.jmp_flg       = cur.jmp_flg;
            wb_next.inst_is_ecall = cur.inst_is_ecall;
            wb_next.wb_sel        = cur.wb_sel;
            wb_next.wb_addr       = cur.wb_addr;
            wb_next.csr_cmd       = cur.csr_cmd;
            wb_next.misaligned    = misaligned;
            wb_next.mem_rdata     = (state == ST_WAIT_DATA) ? load_result : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
            saved <= stage_nop();
            wb_q  <= wb_bubble();
        end else begin
            state <= state_next;
            wb_q  <= wb_next;
            if (state == ST_IDLE) saved <= in_stage;
        end
    end

    always_comb begin
        dmem_wmask = 4'b0000;
        dmem_wdata = 32'd0;
        if (cmd_start && store) begin
            case (cur.mem_wen)
                MEN_SB: begin
                    dmem_wmask = 4'b0001 << cur.alu_out[1:0];
                    dmem_wdata = {4{cur.rs2_data[7:0]}};
                end
                MEN_SH: begin
                    dmem_wmask = cur.alu_out[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{cur.rs2_data[15:0]}};
                end
                MEN_SW: begin
                    dmem_wmask = 4'b1111;
                    dmem_wdata = cur.rs2_data;
                end
                default: ;
            endcase
        end
    end

    assign mem_stall_flg  = stall;
    assign dmem_cmd_start = cmd_start;
    assign dmem_cmd_write = cmd_start & store;
    assign dmem_addr      = cmd_start ? {cur.alu_out[ADDR_W-1:2], 2'b00} : '0;

    assign output_reg_pc        = wb_q.reg_pc;
    assign output_alu_out       = wb_q.alu_out;
    assign output_op1_data      = wb_q.op1_data;
    assign output_imm_i         = wb_q.imm_i;
    assign output_rf_wen        = wb_q.rf_wen;
    assign output_jmp_flg       = wb_q.jmp_flg;
    assign output_inst_is_ecall = wb_q.inst_is_ecall;
    assign output_wb_sel        = wb_q.wb_sel;
    assign output_wb_addr       = wb_q.wb_addr;
    assign output_csr_cmd       = wb_q.csr_cmd;
    assign output_mem_rdata     = wb_q.mem_rdata;
    assign output_misaligned    = wb_q.misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: ALU pass-through, stores,
// loads with extension, misalignment, flush/drain and reset mid-access.
module tb_memory_stage;

    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_branch_hazard;
    logic [31:0] input_reg_pc, input_alu_out, input_rs2_data, input_op1_data, input_imm_i;
    logic [4:0]  input_mem_wen, input_wb_addr;
    logic        input_rf_wen, input_jmp_flg, input_inst_is_ecall;
    logic [3:0]  input_wb_sel;
    logic [2:0]  input_csr_cmd;
    logic        mem_stall_flg, dmem_cmd_start, dmem_cmd_write;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_cmd_ready, dmem_rdata_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] output_reg_pc, output_alu_out, output_op1_data, output_imm_i, output_mem_rdata;
    logic        output_rf_wen, output_jmp_flg, output_inst_is_ecall, output_misaligned;
    logic [3:0]  output_wb_sel;
    logic [4:0]  output_wb_addr;
    logic [2:0]  output_csr_cmd;

    int n_checks = 0;
    int n_errors = 0;
    int stall_cnt, cmd_cnt;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset), .wb_branch_hazard(wb_branch_hazard),
        .input_reg_pc(input_reg_pc), .input_alu_out(input_alu_out),
        .input_mem_wen(input_mem_wen), .input_rs2_data(input_rs2_data),
        .input_rf_wen(input_rf_wen), .input_wb_sel(input_wb_sel),
        .input_wb_addr(input_wb_addr), .input_csr_cmd(input_csr_cmd),
        .input_op1_data(input_op1_data), .input_imm_i(input_imm_i),
        .input_jmp_flg(input_jmp_flg), .input_inst_is_ecall(input_inst_is_ecall),
        .mem_stall_flg(mem_stall_flg), .dmem_cmd_start(dmem_cmd_start),
        .dmem_cmd_write(dmem_cmd_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_cmd_ready(dmem_cmd_ready), .dmem_rdata(dmem_rdata),
        .dmem_rdata_valid(dmem_rdata_valid),
        .output_reg_pc(output_reg_pc), .output_alu_out(output_alu_out),
        .output_op1_data(output_op1_data), .output_imm_i(output_imm_i),
        .output_rf_wen(output_rf_wen), .output_jmp_flg(output_jmp_flg),
        .output_inst_is_ecall(output_inst_is_ecall), .output_wb_sel(output_wb_sel),
        .output_wb_addr(output_wb_addr), .output_csr_cmd(output_csr_cmd),
        .output_mem_rdata(output_mem_rdata), .output_misaligned(output_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] men,
                            input logic [31:0] rs2, input logic rf, input logic [4:0] wa);
        input_reg_pc   = pc;
        input_alu_out  = alu;
        input_mem_wen  = men;
        input_rs2_data = rs2;
        input_rf_wen   = rf;
        input_wb_addr  = wa;
    endtask

    // Ready pulses at cycle ready_at, data valid at cycle valid_at (counted from issue).
    task automatic run_load(input logic [4:0] men, input logic [31:0] addr, input logic [31:0] pc,
                            input logic [31:0] rdata, input int ready_at, input int valid_at,
                            output int stalls, output int cmds);
        stalls = 0;
        cmds   = 0;
        set_inst(pc, addr, men, 32'd0, 1'b1, 5'd9);
        for (int i = 0; i <= valid_at; i++) begin
            dmem_cmd_ready   = (i == ready_at);
            dmem_rdata_valid = (i == valid_at);
            dmem_rdata       = (i == valid_at) ? rdata : 32'hdeadbeef;
            #1;
            if (mem_stall_flg)  stalls++;
            if (dmem_cmd_start) cmds++;
            step();
        end
        dmem_cmd_ready   = 1'b0;
        dmem_rdata_valid = 1'b0;
        set_inst(32'h0, 32'h0, MEN_X, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        wb_branch_hazard = 1'b0;
        set_inst(32'h0, 32'h0, MEN_X, 32'd0, 1'b0, 5'd0);
        input_wb_sel = WB_ALU; input_csr_cmd = CSR_X;
        input_op1_data = 32'h55; input_imm_i = 32'h66;
        input_jmp_flg = 1'b0; input_inst_is_ecall = 1'b0;
        dmem_cmd_ready = 1'b0; dmem_rdata_valid = 1'b0; dmem_rdata = 32'd0;

        step(); step();
        check("reset_pc", output_reg_pc, 32'hffffffff);
        check("reset_rf_wen", {31'd0, output_rf_wen}, 32'd0);
        check("reset_alu", output_alu_out, 32'd0);
        check("reset_cmd", {31'd0, dmem_cmd_start}, 32'd0);
        reset = 1'b0;

        // ALU op passes through with one cycle latency.
        set_inst(32'h100, 32'h1234, MEN_X, 32'd0, 1'b1, 5'd5);
        #1;
        check("alu_stall", {31'd0, mem_stall_flg}, 32'd0);
        check("alu_cmd", {31'd0, dmem_cmd_start}, 32'd0);
        step();
        check("alu_out", output_alu_out, 32'h1234);
        check("alu_pc", output_reg_pc, 32'h100);
        check("alu_wb_addr", {27'd0, output_wb_addr}, 32'd5);
        check("alu_imm", output_imm_i, 32'h66);

        // SB accepted immediately.
        set_inst(32'h104, 32'h103, MEN_SB, 32'haabbccdd, 1'b0, 5'd0);
        dmem_cmd_ready = 1'b1;
        #1;
        check("sb_cmd", {31'd0, dmem_cmd_start}, 32'd1);
        check("sb_write", {31'd0, dmem_cmd_write}, 32'd1);
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_mask", {28'd0, dmem_wmask}, 32'h8);
        check("sb_wdata", dmem_wdata, 32'hdddddddd);
        check("sb_stall", {31'd0, mem_stall_flg}, 32'd0);
        step();
        check("sb_out_pc", output_reg_pc, 32'h104);

        // SH to the upper half.
        set_inst(32'h108, 32'h2, MEN_SH, 32'h1122beef, 1'b0, 5'd0);
        #1;
        check("sh_mask", {28'd0, dmem_wmask}, 32'hc);
        check("sh_wdata", dmem_wdata, 32'hbeefbeef);
        check("sh_addr", dmem_addr, 32'h0);
        step();
        dmem_cmd_ready = 1'b0;

        // LH/LHU with a slow port: 5 stall cycles, 3 request cycles.
        run_load(MEN_LH, 32'h202, 32'h200, 32'h80010000, 2, 5, stall_cnt, cmd_cnt);
        check("lh_data", output_mem_rdata, 32'hffff8001);
        check("lh_pc", output_reg_pc, 32'h200);
        check("lh_rf_wen", {31'd0, output_rf_wen}, 32'd1);
        check("lh_stall_cycles", stall_cnt, 32'd5);
        check("lh_cmd_cycles", cmd_cnt, 32'd3);
        run_load(MEN_LHU, 32'h202, 32'h210, 32'h80010000, 2, 5, stall_cnt, cmd_cnt);
        check("lhu_data", output_mem_rdata, 32'h00008001);
        run_load(MEN_LB, 32'h301, 32'h220, 32'h00008000, 0, 1, stall_cnt, cmd_cnt);
        check("lb_data", output_mem_rdata, 32'hffffff80);
        check("lb_stall_cycles", stall_cnt, 32'd1);
        run_load(MEN_LW, 32'h304, 32'h230, 32'hcafef00d, 0, 2, stall_cnt, cmd_cnt);
        check("lw_data", output_mem_rdata, 32'hcafef00d);
        check("lw_wb_addr", {27'd0, output_wb_addr}, 32'd9);

        // Misaligned word load: no request, flagged next cycle.
        set_inst(32'h240, 32'h6, MEN_LW, 32'd0, 1'b1, 5'd4);
        #1;
        check("mis_cmd", {31'd0, dmem_cmd_start}, 32'd0);
        check("mis_stall", {31'd0, mem_stall_flg}, 32'd0);
        step();
        check("mis_flag", {31'd0, output_misaligned}, 32'd1);
        check("mis_rf_wen", {31'd0, output_rf_wen}, 32'd0);
        check("mis_pc", output_reg_pc, 32'h240);

        // Flush while waiting for data: drain, then emit a bubble.
        set_inst(32'h400, 32'h400, MEN_LW, 32'd0, 1'b1, 5'd3);
        dmem_cmd_ready = 1'b1;
        #1;
        check("drain_cmd", {31'd0, dmem_cmd_start}, 32'd1);
        step();
        dmem_cmd_ready = 1'b0;
        wb_branch_hazard = 1'b1;
        set_inst(32'h0, 32'h0, MEN_X, 32'd0, 1'b0, 5'd0);
        #1;
        check("drain_flush_stall", {31'd0, mem_stall_flg}, 32'd1);
        step();
        wb_branch_hazard = 1'b0;
        #1;
        check("drain_stall", {31'd0, mem_stall_flg}, 32'd1);
        check("drain_no_cmd", {31'd0, dmem_cmd_start}, 32'd0);
        step();
        check("drain_bubble_pc", output_reg_pc, 32'hffffffff);
        dmem_rdata_valid = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        check("drain_valid_stall", {31'd0, mem_stall_flg}, 32'd0);
        step();
        dmem_rdata_valid = 1'b0;
        check("drain_out_pc", output_reg_pc, 32'hffffffff);
        check("drain_out_data", output_mem_rdata, 32'd0);
        set_inst(32'h500, 32'h77, MEN_X, 32'd0, 1'b1, 5'd2);
        #1;
        check("after_drain_stall", {31'd0, mem_stall_flg}, 32'd0);
        step();
        check("after_drain_pc", output_reg_pc, 32'h500);

        // Flush together with rdata_valid: straight back to IDLE.
        set_inst(32'h600, 32'h600, MEN_LW, 32'd0, 1'b1, 5'd3);
        dmem_cmd_ready = 1'b1;
        step();
        dmem_cmd_ready = 1'b0;
        wb_branch_hazard = 1'b1; dmem_rdata_valid = 1'b1;
        set_inst(32'h700, 32'h0, MEN_X, 32'd0, 1'b0, 5'd0);
        #1;
        check("flushvalid_stall", {31'd0, mem_stall_flg}, 32'd0);
        step();
        wb_branch_hazard = 1'b0; dmem_rdata_valid = 1'b0;
        check("flushvalid_pc", output_reg_pc, 32'hffffffff);
        check("flushvalid_rf_wen", {31'd0, output_rf_wen}, 32'd0);
        #1;
        check("flushvalid_idle_stall", {31'd0, mem_stall_flg}, 32'd0);
        step();
        check("flushvalid_next_pc", output_reg_pc, 32'h700);

        // Reset while waiting for ready.
        set_inst(32'h800, 32'h300, MEN_SW, 32'h01020304, 1'b0, 5'd0);
        step();
        #1;
        check("wr_stall", {31'd0, mem_stall_flg}, 32'd1);
        check("wr_cmd", {31'd0, dmem_cmd_start}, 32'd1);
        reset = 1'b1;
        set_inst(32'h900, 32'h0, MEN_X, 32'd0, 1'b0, 5'd0);
        step();
        reset = 1'b0;
        #1;
        check("rst_mid_cmd", {31'd0, dmem_cmd_start}, 32'd0);
        check("rst_mid_stall", {31'd0, mem_stall_flg}, 32'd0);
        check("rst_mid_pc", output_reg_pc, 32'hffffffff);
        // A stray rdata_valid in IDLE must not leak into the result.
        dmem_rdata_valid = 1'b1; dmem_rdata = 32'hffffffff;
        step();
        dmem_rdata_valid = 1'b0;
        check("late_valid_data", output_mem_rdata, 32'd0);
        check("late_valid_pc", output_reg_pc, 32'h900);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its registered outputs and feeds the writeback stage.
- Performs loads and stores over a request/response data-memory port, with byte-lane steering and load sign/zero extension.
- Asserts a stall to freeze upstream stages while a memory access is outstanding; passes non-memory instructions through in one cycle.

Parameters:
- ADDR_W, 32, data-memory address width
- REGPC_NOP, 32'hffffffff, reg_pc value marking a bubble

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_branch_hazard  in  1  flush request; kills this stage's instruction
- input_reg_pc  in  32  from execute output_reg_pc
- input_alu_out  in  32  effective address, or ALU result
- input_mem_wen  in  5  memory op code (MEN_*)
- input_rs2_data  in  32  store data
- input_rf_wen  in  1  register-write enable
- input_wb_sel  in  4  writeback select
- input_wb_addr  in  5  destination register
- input_csr_cmd  in  3  passed through
- input_op1_data  in  32  passed through
- input_imm_i  in  32  passed through
- input_jmp_flg  in  1  passed through
- input_inst_is_ecall  in  1  passed through
- mem_stall_flg  out  1  combinational; upstream holds while high
- dmem_cmd_start  out  1  request valid
- dmem_cmd_write  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  word-aligned address ({alu_out[31:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_wmask  out  4  byte-lane enables
- dmem_cmd_ready  in  1  request accepted this cycle
- dmem_rdata  in  32  load data word
- dmem_rdata_valid  in  1  load data valid
- output_reg_pc, output_alu_out, output_op1_data, output_imm_i  out  32  to writeback
- output_rf_wen, output_jmp_flg, output_inst_is_ecall  out  1  to writeback
- output_wb_sel  out  4  to writeback
- output_wb_addr  out  5  to writeback
- output_csr_cmd  out  3  to writeback
- output_mem_rdata  out  32  extended load result
- output_misaligned  out  1  misaligned access flag

Behaviour:
- MEN codes: X=0, SB=1, SH=2, SW=3, LB=4, LBU=5, LH=6, LHU=7, LW=8. Any other value is treated as X.
- Reset: state=IDLE. All outputs are 0 except output_reg_pc=REGPC_NOP. dmem_cmd_start=0. Save registers are cleared to a NOP.
- Stage inputs are muxed exactly as in execute: when mem_stall_flg is high, use the saved copy; otherwise use the input_* ports. The saved copy is loaded whenever the stall is low.
- FSM states:
  - IDLE: non-memory op → outputs registered next cycle (1-cycle latency), no stall. Memory op → drive cmd in the same cycle.
    - cmd_ready=1 and store → done this cycle.
    - cmd_ready=1 and load → WAIT_DATA.
    - cmd_ready=0 → WAIT_READY.
    - While not done, mem_stall_flg=1 and outputs emit a bubble.
  - WAIT_READY: cmd held stable until ready. On ready: store → IDLE (complete); load → WAIT_DATA.
  - WAIT_DATA: stall until rdata_valid. Then register the extended data, present the instruction to writeback, → IDLE.
  - DRAIN: load already accepted but flushed. Stall until rdata_valid, discard the data, emit a bubble, → IDLE.
- Lanes:
  - SB: mask = 1 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: mask = 0011 or 1100 selected by addr[1], wdata = {2{rs2[15:0]}}.
  - SW: mask = 1111.
- Loads: select the byte or half from rdata by addr[1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0): no bus request. output_misaligned=1 and rf_wen=0, emitted in the next cycle.
- Flush (wb_branch_hazard), all cases: output_reg_pc=REGPC_NOP and rf_wen=0, wb_addr=0, jmp_flg=0, ecall=0, misaligned=0.
  - Flush in IDLE or WAIT_READY: the request is dropped; cmd_start goes low the next cycle → IDLE.
  - Flush in WAIT_DATA: → DRAIN.
  - Flush and rdata_valid in the same cycle: data is discarded → IDLE.
- dmem_cmd_start is never asserted in WAIT_DATA or DRAIN (one outstanding access maximum).
- Reset mid-access: FSM → IDLE immediately. A late rdata_valid in IDLE is ignored.

Decomposition:
- Shared core package/include: MEN_* codes, WB_*, CSR_X, REN_X, REGPC_NOP, and the FSM state encoding.
- One sub-module, load_align: combinational rdata/addr[1:0]/MEN → extended 32-bit result.

Test Plan:
- ALU op (MEN_X), alu_out=0x1234 → output_alu_out=0x1234 one cycle later; mem_stall_flg stays 0.
- SB with addr=0x103, rs2=0xAABBCCDD, ready=1 immediately → wmask=1000, wdata=0xDDDDDDDD, dmem_addr=0x100, no stall.
- LH with addr=0x202, ready after 2 cycles, rdata=0x8001_0000 valid 3 cycles later → stall high 5 cycles, output_mem_rdata=0xFFFF8001; LHU variant → 0x00008001.
- LW with addr=0x6 → no cmd_start, output_misaligned=1, rf_wen=0.
- LW accepted, then wb_branch_hazard in WAIT_DATA, rdata_valid 2 cycles later → stall held until valid, output is a bubble (reg_pc=0xffffffff), data discarded.
- reset asserted during WAIT_READY → next cycle IDLE, cmd_start=0, outputs at reset values.
